counter_access_arbiter: RTL and testbench

- Shares the counter core's register port among NUM_REQ bus requesters.
- Each requester issues single-beat reads/writes. The block picks a winner round-robin, drives one-cycle register strobes and data into the core, returns read data, and keeps a sticky interrupt-pending flag.
- Sits between the requester fabric and the counter core; it is the only driver of the core's register control inputs.

---
 rtl/counter_access_arbiter.sv | 155 +++++++++++++++
 tb/tb_counter_access_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_access_arbiter.sv
// Round-robin arbiter sharing the counter core's register port among NUM_REQ requesters.
// Each accepted request runs IDLE -> ACCESS (core strobe) -> RESPOND (response pulse).
module counter_access_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     reqValid,
  input  logic [NUM_REQ-1:0]     reqWrite,
  input  logic [2*NUM_REQ-1:0]   reqAddr,
  input  logic [32*NUM_REQ-1:0]  reqWdata,
  output logic [NUM_REQ-1:0]     reqReady,
  output logic [NUM_REQ-1:0]     rspValid,
  output logic [31:0]            rspRdata,
  output logic [31:0]            counterIn,
  output logic                   counterEnIn,
  output logic                   counterDirIn,
  output logic                   counterIreIn,
  output logic                   counterWe,
  output logic                   counterRe,
  output logic                   counterConfigWe,
  output logic                   counterConfigRe,
  output logic                   counterStatusRe,
  input  logic [31:0]            counterOut,
  input  logic                   counterEnOut,
  input  logic                   counterDirOut,
  input  logic                   counterIreOut,
  input  logic                   counterLT1000Out,
  input  logic                   counterIrq,
  output logic                   irq
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t          r_state, w_next;
  logic [GW-1:0]   r_lastGrant, r_win, w_win, w_cand;
  logic            w_found, w_accept, w_clr;
  logic            r_wr, r_w0, r_pend;
  logic [1:0]      r_addr;
  logic [31:0]     r_rdata, w_rdata;
  logic            w_wr;
  logic [1:0]      w_addr;
  logic [31:0]     w_wdata;

  // First requesting index searching upward from lastGrant+1, wrapping at NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = GW'((int'(r_lastGrant) + k) % NUM_REQ);
      if (!w_found && reqValid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_wr     = reqWrite[w_win];
  assign w_addr   = reqAddr[{w_win, 1'b0} +: 2];
  assign w_wdata  = reqWdata[{w_win, 5'b0} +: 32];
  assign w_accept = (r_state == IDLE) && w_found && !reset;
  assign w_clr    = (r_state == ACCESS) && r_wr && (r_addr == 2'd3) && r_w0;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Handshake pulses are suppressed while reset is high so a reset in RESPOND drops the response.
  always_comb begin
    w_next   = r_state;
    reqReady = '0;
    rspValid = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_next          = ACCESS;
          reqReady[w_win] = !reset;
        end
      end
      ACCESS:  w_next = RESPOND;
      RESPOND: begin
        w_next          = IDLE;
        rspValid[r_win] = !reset;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (r_addr)
      2'd0:    w_rdata = counterOut;
      2'd1:    w_rdata = {29'b0, counterIreOut, counterDirOut, counterEnOut};
      2'd2:    w_rdata = {31'b0, counterLT1000Out};
      default: w_rdata = {31'b0, r_pend};
    endcase
  end

  // Strobes are registered at accept so they appear for exactly the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastGrant     <= GW'(NUM_REQ - 1);
      r_win           <= '0;
      r_wr            <= 1'b0;
      r_addr          <= '0;
      r_w0            <= 1'b0;
      r_rdata         <= '0;
      r_pend          <= 1'b0;
      counterIn       <= '0;
      counterEnIn     <= 1'b0;
      counterDirIn    <= 1'b0;
      counterIreIn    <= 1'b0;
      counterWe       <= 1'b0;
      counterRe       <= 1'b0;
      counterConfigWe <= 1'b0;
      counterConfigRe <= 1'b0;
      counterStatusRe <= 1'b0;
    end else begin
      counterWe       <= 1'b0;
      counterRe       <= 1'b0;
      counterConfigWe <= 1'b0;
      counterConfigRe <= 1'b0;
      counterStatusRe <= 1'b0;
      if (w_accept) begin
        r_win           <= w_win;
        r_wr            <= w_wr;
        r_addr          <= w_addr;
        r_w0            <= w_wdata[0];
        counterWe       <= w_wr  && (w_addr == 2'd0);
        counterConfigWe <= w_wr  && (w_addr == 2'd1);
        counterRe       <= !w_wr && (w_addr == 2'd0);
        counterConfigRe <= !w_wr && (w_addr == 2'd1);
        counterStatusRe <= !w_wr && (w_addr == 2'd2);
        if (w_wr && (w_addr == 2'd0)) counterIn <= w_wdata;
        if (w_wr && (w_addr == 2'd1)) begin
          counterEnIn  <= w_wdata[0];
          counterDirIn <= w_wdata[1];
          counterIreIn <= w_wdata[2];
        end
      end
      if (r_state == ACCESS)  r_rdata     <= r_wr ? 32'd0 : w_rdata;
      if (r_state == RESPOND) r_lastGrant <= r_win;
      // A new interrupt in the same cycle as a W1C clear keeps the flag set.
      r_pend <= counterIrq | (r_pend & ~w_clr);
    end
  end

  assign rspRdata = r_rdata;
  assign irq      = r_pend;

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Randomised bench for counter_access_arbiter: a transaction-level reference model predicts
// grants, strobes and responses; a separate monitor scores responses from a queue.
module tb_counter_access_arbiter;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      reqValid = '0, reqWrite = '0;
  logic [2*N-1:0]    reqAddr = '0;
  logic [32*N-1:0]   reqWdata = '0;
  logic [N-1:0]      reqReady, rspValid;
  logic [31:0]       rspRdata, counterIn;
  logic              counterEnIn, counterDirIn, counterIreIn;
  logic              counterWe, counterRe, counterConfigWe, counterConfigRe, counterStatusRe;
  logic [31:0]       counterOut = '0;
  logic              counterEnOut = 0, counterDirOut = 0, counterIreOut = 0, counterLT1000Out = 0;
  logic              counterIrq = 0;
  logic              irq;

  counter_access_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqWdata(reqWdata),
    .reqReady(reqReady), .rspValid(rspValid), .rspRdata(rspRdata),
    .counterIn(counterIn), .counterEnIn(counterEnIn), .counterDirIn(counterDirIn),
    .counterIreIn(counterIreIn), .counterWe(counterWe), .counterRe(counterRe),
    .counterConfigWe(counterConfigWe), .counterConfigRe(counterConfigRe),
    .counterStatusRe(counterStatusRe), .counterOut(counterOut), .counterEnOut(counterEnOut),
    .counterDirOut(counterDirOut), .counterIreOut(counterIreOut),
    .counterLT1000Out(counterLT1000Out), .counterIrq(counterIrq), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0;
  bit model_on = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  typedef struct { int w; bit wr; bit [1:0] addr; bit [31:0] wd; int t; } txn_t;
  typedef struct { int w; bit [31:0] d; int due; } rsp_t;

  txn_t acc_q[$];
  rsp_t exp_q[$];

  int        m_last = N - 1;
  int        m_free = 0;
  bit        m_pend = 0;
  bit [31:0] m_cin  = 0;
  bit [2:0]  m_cfg  = 0;

  function automatic int rr(int last, logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Reference model: one transaction in flight, accepted at t, core access at t+1, response at t+2.
  always @(negedge clk) if (model_on) begin : model
    txn_t tx;
    bit [4:0] es;
    bit [N-1:0] er;
    bit clr;
    bit [31:0] rd;
    int w;
    es = 0; er = 0; clr = 0; rd = 0; w = 0;
    chk("irq", irq, m_pend);
    chk("counterIn", counterIn, m_cin);
    chk("cfgIn", {counterIreIn, counterDirIn, counterEnIn}, m_cfg);
    if (acc_q.size() != 0 && acc_q[0].t == cyc - 1) begin
      tx = acc_q.pop_front();
      if (tx.wr) begin
        es[4] = (tx.addr == 0);
        es[2] = (tx.addr == 1);
        clr   = (tx.addr == 3) && tx.wd[0];
      end else begin
        es[3] = (tx.addr == 0);
        es[1] = (tx.addr == 1);
        es[0] = (tx.addr == 2);
        case (tx.addr)
          0: rd = counterOut;
          1: rd = {29'b0, counterIreOut, counterDirOut, counterEnOut};
          2: rd = {31'b0, counterLT1000Out};
          default: rd = {31'b0, m_pend};
        endcase
      end
      if (!reset) exp_q.push_back(rsp_t'{tx.w, rd, cyc + 1});
    end
    chk("strobes", {counterWe, counterRe, counterConfigWe, counterConfigRe, counterStatusRe}, es);
    if (!reset && cyc >= m_free && reqValid != 0) begin
      w = rr(m_last, reqValid);
      er[w] = 1'b1;
      acc_q.push_back(txn_t'{w, reqWrite[w], reqAddr[2*w +: 2], reqWdata[32*w +: 32], cyc});
      m_free = cyc + 3;
      m_last = w;
      if (reqWrite[w] && reqAddr[2*w +: 2] == 2'd0) m_cin = reqWdata[32*w +: 32];
      if (reqWrite[w] && reqAddr[2*w +: 2] == 2'd1) m_cfg = reqWdata[32*w +: 3];
    end
    chk("reqReady", reqReady, er);
    m_pend = counterIrq | (m_pend & !clr);
    if (reset) begin
      m_last = N - 1; m_free = 0; m_pend = 0; m_cin = 0; m_cfg = 0;
      acc_q.delete();
      exp_q.delete();
    end
  end

  // Response monitor: pops the oldest expected response whenever the DUT presents one.
  always @(negedge clk) if (model_on) begin : mon
    rsp_t r;
    if (rspValid != 0) begin
      if (exp_q.size() == 0) chk("rspUnexpected", rspValid, '0);
      else begin
        r = exp_q.pop_front();
        chk("rspValid", rspValid, 64'd1 << r.w);
        chk("rspRdata", rspRdata, r.d);
        chk("rspTime", cyc, r.due);
      end
    end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
      r = exp_q.pop_front();
      chk("rspMissing", cyc, r.due);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds one request until accepted (bounded), returns 1 ns into the ACCESS cycle.
  task automatic do_req(int i, bit wr, bit [1:0] a, bit [31:0] d);
    bit got;
    got = 0;
    reqValid[i] = 1'b1;
    reqWrite[i] = wr;
    reqAddr[2*i +: 2] = a;
    reqWdata[32*i +: 32] = d;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk);
      got = reqReady[i];
      @(posedge clk);
      #1;
    end
    if (!got) chk("reqTimeout", got, 1);
    reqValid[i] = 1'b0;
  endtask

  initial begin : main
    logic [N-1:0] rdy;
    tick();
    model_on = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("rst_rspRdata", rspRdata, 0);
    chk("rst_rspValid", rspValid, 0);
    chk("rst_irq", irq, 0);
    tick();

    do_req(0, 1, 2'd0, 32'h0000_1234); tick(); tick();

    counterEnOut = 1; counterDirOut = 0; counterIreOut = 1;
    do_req(1, 1, 2'd1, 32'h5); tick(); tick();
    do_req(1, 0, 2'd1, 32'h0); tick(); tick();
    chk("cfg_readback", rspRdata, 32'h5);

    counterIrq = 1; tick(); counterIrq = 0; tick();
    chk("irq_set", irq, 1);
    do_req(0, 0, 2'd3, 32'h0); tick(); tick();
    chk("irq_read", rspRdata, 32'h1);
    do_req(0, 1, 2'd3, 32'h1); tick();
    chk("irq_clear", irq, 0);
    tick();
    counterIrq = 1; tick(); counterIrq = 0; tick();
    do_req(1, 1, 2'd3, 32'h1);
    counterIrq = 1; tick(); counterIrq = 0;
    chk("irq_set_wins", irq, 1);
    tick();
    do_req(0, 1, 2'd3, 32'h0); tick(); tick();
    chk("irq_w1c_zero", irq, 1);

    do_req(0, 1, 2'd2, 32'hFFFF_FFFF); tick(); tick();
    chk("ro_write_rdata", rspRdata, 32'h0);
    counterLT1000Out = 1;
    do_req(1, 0, 2'd2, 32'h0); tick(); tick();
    chk("status_read", rspRdata, 32'h1);

    // Reset during RESPOND, then sustained contention from both requesters.
    do_req(1, 0, 2'd0, 32'h0); tick();
    reset = 1; tick(); reset = 0;
    reqValid = '1; reqWrite = '0; reqAddr = '0;
    @(negedge clk);
    chk("post_reset_grant", reqReady, 2'b01);
    @(posedge clk); #1;
    repeat (14) begin
      counterOut = $urandom;
      tick();
    end
    reqValid = '0;
    repeat (3) tick();

    repeat (600) begin
      @(negedge clk);
      rdy = reqReady;
      @(posedge clk);
      #1;
      counterOut = $urandom;
      {counterEnOut, counterDirOut, counterIreOut, counterLT1000Out} = 4'($urandom);
      counterIrq = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        if (reqValid[i] && rdy[i]) reqValid[i] = 1'b0;
        if (!reqValid[i] && $urandom_range(0, 2) == 0) begin
          reqValid[i] = 1'b1;
          reqWrite[i] = 1'($urandom_range(0, 1));
          reqAddr[2*i +: 2] = 2'($urandom);
          reqWdata[32*i +: 32] = $urandom;
        end
      end
    end
    reqValid = '0;
    counterIrq = 0;
    repeat (6) tick();
    chk("drain", exp_q.size() + acc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
